// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//   Front end of the SPI master. Host command words are buffered in a small
//   FIFO; one master transaction is launched per word, only while the master
//   is idle (CS high). Completion is tracked by watching CS (active-low).
//   A programmable inter-frame gap follows every transaction. A start
//   timeout catches a master that never responds. Finished transactions
//   are counted.
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data    host enqueue; ignored while full
//   full, empty       FIFO status
//   level             FIFO occupancy, 0..DEPTH
//   CS                chip select observed from the master, active-low
//   transaction_stb   one-cycle launch strobe to the master
//   tx_word           word of the current transaction, held until next pop
//   busy              FSM is not in IDLE
//   err_timeout       sticky: CS did not fall within TIMEOUT after a launch
//   done_cnt          completed transactions, wraps 255 -> 0
module spi_txn_scheduler #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     CS,
  output logic                     transaction_stb,
  output logic [WIDTH-1:0]         tx_word,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [7:0]               done_cnt
);

  localparam int AW    = $clog2(DEPTH);
  // Timeout counter runs 0..TIMEOUT-1; gap counter runs 0..GLAST.
  localparam int TLAST = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;
  localparam int TW    = (TLAST > 1) ? $clog2(TLAST + 1) : 1;
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW    = (GLAST > 1) ? $clog2(GLAST + 1) : 1;

  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] TLAST_V  = TW'(TLAST);
  localparam logic [GW-1:0] GLAST_V  = GW'(GLAST);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END,
    GAP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic              push, pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push = wr_en && !full;
  // Pop decision looks only at registered level, so a word written this
  // edge is not launchable until the next one (no bypass).
  assign pop  = (state == IDLE) && !empty && CS;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Launch/track FSM. transaction_stb is high exactly while in LAUNCH;
  // busy is registered alongside every state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      transaction_stb <= 1'b0;
      tx_word         <= '0;
      busy            <= 1'b0;
      err_timeout     <= 1'b0;
      done_cnt        <= '0;
      tcnt            <= '0;
      gcnt            <= '0;
    end else begin
      transaction_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_word         <= mem[rptr];
            transaction_stb <= 1'b1;
            busy            <= 1'b1;
            state           <= LAUNCH;
          end
        end
        LAUNCH: begin
          tcnt  <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          // CS falling wins over an expiring timeout in the same cycle.
          // The counter counts WAIT_START cycles that saw CS high; the
          // TIMEOUT-th such cycle raises the error and drops the word.
          if (!CS) begin
            state <= WAIT_END;
          end else if (tcnt == TLAST_V) begin
            err_timeout <= 1'b1;
            gcnt        <= '0;
            state       <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_END: begin
          if (CS) begin
            done_cnt <= done_cnt + 8'd1;
            gcnt     <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          // GAP_CYCLES of 0 or 1 both give a single GAP cycle.
          if (gcnt == GLAST_V) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler. A timestamp-based reference
// model predicts launches, FIFO occupancy and status; predicted launches
// go into a scoreboard that an independent monitor drains whenever the DUT
// strobes. A behavioural SPI master answers strobes on CS.
module tb_spi_txn_scheduler;
  localparam int WIDTH      = 16;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 64;
  localparam int GAP_LEN    = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             full, empty, stb, busy, err;
  logic [2:0]       level;
  logic             cs;
  logic [WIDTH-1:0] tx_word;
  logic [7:0]       done_cnt;

  always #5 clk = ~clk;

  spi_txn_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .CS(cs),
    .transaction_stb(stb), .tx_word(tx_word), .busy(busy),
    .err_timeout(err), .done_cnt(done_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural master ----------------
  logic mcs = 1'b1;
  bit   foreign = 1'b0;   // another master holding CS low
  bit   never = 1'b0;     // master ignores strobes
  int   d1_fix = 0, d2_fix = 0;
  int   mph = 0, mcnt = 0;
  assign cs = mcs & ~foreign;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mcs = 1'b1;
      mph = 0;
    end else begin
      case (mph)
        0: if (stb && !never) begin
             mcnt = (d1_fix > 0) ? d1_fix : int'($urandom_range(1, 10));
             mph  = 1;
           end
        1: begin
             mcnt--;
             if (mcnt == 0) begin
               mcs  = 1'b0;
               mcnt = (d2_fix > 0) ? d2_fix : int'($urandom_range(1, 15));
               mph  = 2;
             end
           end
        default: begin
             mcnt--;
             if (mcnt == 0) begin
               mcs = 1'b1;
               mph = 0;
             end
           end
      endcase
    end
  end

  // ---------------- reference model ----------------
  // Edge n is the n-th rising clock edge. The scheduler is free to launch at
  // edge free_edge or later; a launch at edge L expects CS low at some edge
  // in L+2 .. L+1+TIMEOUT, else the word is dropped with an error.
  typedef struct { logic [WIDTH-1:0] w; int e; } exp_t;
  logic [WIDTH-1:0] mq[$];
  exp_t             sb[$];
  int               n = 0, inflight = 0, launch_edge = 0, free_edge = 0;
  logic [7:0]       m_done = '0;
  logic             m_err = 1'b0;
  logic [WIDTH-1:0] m_tx = '0;
  bit               md_full;
  exp_t             md_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      inflight  = 0;
      free_edge = 0;
      m_done    = '0;
      m_err     = 1'b0;
      m_tx      = '0;
    end else begin
      n++;
      md_full = (mq.size() == DEPTH);
      if (inflight == 0) begin
        if (n >= free_edge && mq.size() > 0 && cs) begin
          md_e.w = mq.pop_front();
          md_e.e = n;
          m_tx   = md_e.w;
          sb.push_back(md_e);
          launch_edge = n;
          inflight    = 1;
        end
      end else if (inflight == 1) begin
        if (n >= launch_edge + 2) begin
          if (!cs) inflight = 2;
          else if (n == launch_edge + 1 + TIMEOUT) begin
            m_err     = 1'b1;
            inflight  = 0;
            free_edge = n + GAP_LEN + 1;
          end
        end
      end else if (cs) begin
        m_done    = m_done + 8'd1;
        inflight  = 0;
        free_edge = n + GAP_LEN + 1;
      end
      if (wr_en && !md_full) mq.push_back(wr_data);
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (stb) begin
        if (sb.size() == 0) chk("stb_unexpected", stb, 0);
        else begin
          mon_e = sb.pop_front();
          chk("launch_word", tx_word, mon_e.w);
          chk("launch_edge", n, mon_e.e);
        end
      end else if (sb.size() > 0 && sb[0].e <= n) begin
        chk("stb_missing", stb, 1);
        mon_e = sb.pop_front();
      end
      chk("level", level, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("busy", busy, (inflight != 0) || (n < free_edge - 1));
      chk("err_timeout", err, m_err);
      chk("done_cnt", done_cnt, m_done);
      chk("tx_word_hold", tx_word, m_tx);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [WIDTH-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((busy || !empty || inflight != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", c);
    end
  endtask

  // Poll cs just after the negedge so the master's update is visible.
  task automatic wait_cs(input logic v, input int maxc, input string nm);
    int c = 0;
    while (cs !== v && c < maxc) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (c >= maxc) begin
      checks++;
      errors++;
      $display("FAIL %s: cs never reached %0b", nm, v);
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic reset_check(input string tag);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({tag, "_rst_stb"}, stb, 0);
    chk({tag, "_rst_tx_word"}, tx_word, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_err"}, err, 0);
    chk({tag, "_rst_done"}, done_cnt, 0);
    chk({tag, "_rst_full"}, full, 0);
    chk({tag, "_rst_empty"}, empty, 1);
    chk({tag, "_rst_level"}, level, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    @(negedge clk);
    reset_check("por");

    // 1: single word, master drops CS 20 cycles after the strobe
    d1_fix = 20;
    d2_fix = 5;
    wr_en = 1'b1;
    wr_data = 16'hA5A5;
    @(negedge clk);           // write edge k has passed
    wr_en = 1'b0;
    @(negedge clk);           // edge k+1 has passed: strobe visible
    chk("t1_stb_latency", stb, 1);
    chk("t1_tx_word", tx_word, 16'hA5A5);
    wait_cs(1'b0, 100, "t1_cs_low");
    wait_cs(1'b1, 100, "t1_cs_high");
    c = 0;
    while (busy && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("t1_busy_fall", c, GAP_CYCLES + 1);
    wait_idle(200);
    chk("t1_done", done_cnt, 1);

    // 4: master never responds -> timeout, word dropped
    never = 1'b1;
    d1_fix = 0;
    d2_fix = 0;
    wr(16'h4444);
    c = 0;
    while (!stb && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("t4_stb_seen", stb, 1);
    @(negedge clk);
    c = 0;
    while (!err && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t4_err_latency", c, TIMEOUT);
    chk("t4_done_unchanged", done_cnt, 1);
    wait_idle(100);

    // 2: six back-to-back writes, CS high; first is popped, sixth dropped
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 16'h1000 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("t2_full", full, 1);
    chk("t2_level", level, DEPTH);

    // 6: write while full with a simultaneous pop -> level DEPTH-1
    wr_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      wr_data = 16'($urandom);
      @(negedge clk);
      if (stb) break;
    end
    wr_en = 1'b0;
    chk("t6_pop_while_full", level, DEPTH - 1);
    wait_idle(1000);
    never = 1'b0;
    @(negedge clk);
    reset_check("mid");

    // 3: three words, normal master with random timing
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'hC000 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle(500);
    chk("t3_done", done_cnt, 3);
    chk("t3_empty", empty, 1);

    // foreign master holds CS low in IDLE: no launch until released
    foreign = 1'b1;
    wr(16'hF00D);
    repeat (6) @(negedge clk);
    chk("foreign_no_launch", busy, 0);
    chk("foreign_level", level, 1);
    foreign = 1'b0;
    wait_idle(200);
    chk("foreign_done", done_cnt, 4);

    // random traffic, including write/pop collisions at various levels
    for (int i = 0; i < 300; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 16'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle(3000);

    // 5: reset while in WAIT_END with words still queued
    d1_fix = 3;
    d2_fix = 40;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'hB000 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_cs(1'b0, 50, "t5_cs_low");
    repeat (3) @(negedge clk);
    chk("t5_busy_before", busy, 1);
    reset_check("t5");
    d1_fix = 0;
    d2_fix = 0;
    repeat (30) @(negedge clk);
    chk("t5_level_after", level, 0);
    chk("t5_done_after", done_cnt, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
